ahbl_sram_slave: RTL and testbench
==================================

# ahbl_sram_slave

AHB-Lite single-slave SRAM responder: the target end of the CPU subsystem's `biu_pad_*` / `pad_biu_*` system bus. It decodes a word-addressed on-chip memory window and answers reads and writes with programmable wait states. It generates a two-cycle ERROR response for illegal accesses and counts those errors. It sits directly on the subsystem's system-bus port as the only slave, so its `pad_biu_hready` is the bus HREADY.

## Interface
- `BASE_ADDR`, default 32'h2000_0000: byte base of the memory window; must be aligned to 4*DEPTH.
- `DEPTH`, default 1024: number of 32-bit words; must be a power of 2, at least 4.
- `WAIT_CYCLES`, default 1: wait states inserted per OKAY transfer; legal range 0..15.
- `cpu_clk`  in  1  bus clock; all logic on rising edge.
- `cpu_rst`  in  1  reset, synchronous, active-high.
- `biu_pad_haddr`  in  32  address-phase address.
- `biu_pad_htrans`  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- `biu_pad_hwrite`  in  1  1 = write.
- `biu_pad_hsize`  in  3  0 byte, 1 halfword, 2 word.
- `biu_pad_hburst`  in  3  ignored; every beat is decoded independently.
- `biu_pad_hprot`  in  4  ignored.
- `biu_pad_hwdata`  in  32  write data, valid in the data phase; little-endian lanes.
- `pad_biu_hrdata`  out  32  read data; always the full addressed word.
- `pad_biu_hready`  out  1  transfer done / bus HREADY.
- `pad_biu_hresp`  out  2  00 OKAY, 01 ERROR; bit 1 is always 0.
- `slv_err_cnt`  out  16  number of ERROR responses issued; saturates at 16'hFFFF.

## Operation
- Address phase is accepted when `pad_biu_hready`=1 and `biu_pad_htrans[1]`=1. Latch addr word index, byte offset, size, write flag, and the legality check.
- IDLE and BUSY transfers cause no access and get a zero-wait OKAY.
- An access is illegal if any of the following holds; an illegal access performs no memory access:
  - address is outside [BASE_ADDR, BASE_ADDR+4*DEPTH);
  - hsize>2;
  - halfword with haddr[0]=1;
  - word with haddr[1:0]≠0.
- Write byte strobes:
  - byte: lane haddr[1:0];
  - halfword: lanes {haddr[1],0} and {haddr[1],1};
  - word: all lanes.
- A write commits `biu_pad_hwdata` on the data-phase cycle where `pad_biu_hready`=1, under the byte strobes.
- A read presents `mem[idx]` on `pad_biu_hrdata` in its final data-phase cycle. The master extracts the byte or halfword lane itself.
- Read-after-write forwarding: if a read's address phase coincides with the completion of a write to the same word, the read returns the merged new data.
- `pad_biu_hrdata` updates only on read completion and holds its value otherwise.
- Memory array is not reset.
- State machine:
  - IDLE: hready=1, hresp=OKAY. On a legal accept, go to WAIT if WAIT_CYCLES>0, else stay in IDLE and the data phase completes next cycle. On an illegal accept, go to ERR1.
  - WAIT: hready=0, hresp=OKAY. Counter loads WAIT_CYCLES-1 and decrements; at 0, go to IDLE, where the data phase completes with hready=1.
  - ERR1: hready=0, hresp=ERROR. Increment `slv_err_cnt` (saturating). Go to ERR2.
  - ERR2: hready=1, hresp=ERROR. Sampling a new address phase here is allowed. Go to WAIT, ERR1, or IDLE per the new transfer.
- Wait states are not applied to ERROR responses.

## Timing
- Reset values: `pad_biu_hready`=1, `pad_biu_hresp`=00, `pad_biu_hrdata`=0, `slv_err_cnt`=0, state=IDLE, counter=0.
- Latency from address phase to completion (hready=1 in the data phase):
  - OKAY transfer: WAIT_CYCLES+1 cycles.
  - ERROR transfer: 2 cycles (ERR1, ERR2).
- Pipelining: the next address phase is sampled in the same cycle the current data phase completes. Back-to-back zero-wait transfers sustain one per cycle.
- Inputs are sampled only when hready=1. Address/control changes during wait cycles are ignored.
- Reset mid-transfer: takes effect at the next edge; the pending write is dropped and outputs return to reset values.
- `slv_err_cnt` increments exactly once per ERROR response, on entry to ERR1, and stops at 16'hFFFF.

## Test plan
- Reset, WAIT_CYCLES=0: NONSEQ word write 32'hDEADBEEF to 0x2000_0010, then a read of the same word back-to-back → read completes the cycle after its address phase with hrdata=32'hDEADBEEF (forwarding path), hresp=00.
- Byte write 8'h5A to 0x2000_0013 over a word of 0, then a word read → hrdata=32'h5A00_0000. Halfword write 16'h1234 to 0x2000_0012 → word reads 32'h1234_0000.
- WAIT_CYCLES=3, word read → hready low exactly 3 cycles after the address phase, then high with data. An address change during the waits has no effect.
- Read of 0x2000_1000 (out of window, DEPTH=1024), then a halfword at 0x2000_0001 → each gives hready 0 then 1 with hresp=01 both cycles; no memory change; slv_err_cnt=2.
- IDLE/BUSY transfers interleaved with SEQ beats → IDLE/BUSY get zero-wait OKAY with no access. Reset asserted during WAIT of a write → write not committed, outputs at reset values the next cycle.
- Force 65536 errors → slv_err_cnt holds at 16'hFFFF on the next error.

Source files
------------

// File: rtl/ahbl_sram_slave.sv
// AHB-Lite SRAM responder for the CPU subsystem system bus: word-addressed memory window,
// programmable wait states, two-cycle ERROR response for illegal accesses and an error counter.
module ahbl_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] biu_pad_haddr,
    input  logic [1:0]  biu_pad_htrans,
    input  logic        biu_pad_hwrite,
    input  logic [2:0]  biu_pad_hsize,
    input  logic [2:0]  biu_pad_hburst,
    input  logic [3:0]  biu_pad_hprot,
    input  logic [31:0] biu_pad_hwdata,
    output logic [31:0] pad_biu_hrdata,
    output logic        pad_biu_hready,
    output logic [1:0]  pad_biu_hresp,
    output logic [15:0] slv_err_cnt
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] WIN_MASK  = ~((32'(DEPTH) << 2) - 32'd1);
    localparam logic        WAIT_EN   = (WAIT_CYCLES > 0) ? 1'b1 : 1'b0;
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] mem_q [DEPTH];

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            dp_valid_q, dp_valid_d;
    logic            dp_write_q, dp_write_d;
    logic [AW-1:0]   dp_idx_q, dp_idx_d;
    logic [3:0]      dp_strb_q, dp_strb_d;
    logic [31:0]     hrdata_q, hrdata_d;
    logic            hready_q, hready_d;
    logic [1:0]      hresp_q, hresp_d;
    logic [15:0]     err_cnt_q, err_cnt_d;

    logic            acc_s, in_win_s, size_ok_s, legal_s, wr_commit_s;
    logic [3:0]      strb_s;
    logic [AW-1:0]   acc_idx_s;
    logic [31:0]     fwd_word_s;
    logic            unused_s;

    assign unused_s = ^{biu_pad_htrans[0], biu_pad_hburst, biu_pad_hprot};

    // Address-phase decode: acceptance, legality, byte strobes and the forwarded read word
    always_comb begin
        acc_s     = hready_q & biu_pad_htrans[1];
        in_win_s  = ((biu_pad_haddr & WIN_MASK) == BASE_ADDR);
        acc_idx_s = biu_pad_haddr[AW+1:2];
        case (biu_pad_hsize)
            3'd0: begin
                size_ok_s = 1'b1;
                strb_s    = 4'b0001 << biu_pad_haddr[1:0];
            end
            3'd1: begin
                size_ok_s = ~biu_pad_haddr[0];
                strb_s    = biu_pad_haddr[1] ? 4'b1100 : 4'b0011;
            end
            3'd2: begin
                size_ok_s = (biu_pad_haddr[1:0] == 2'b00);
                strb_s    = 4'b1111;
            end
            default: begin
                size_ok_s = 1'b0;
                strb_s    = 4'b0000;
            end
        endcase
        legal_s     = in_win_s & size_ok_s;
        wr_commit_s = (state_q == ST_IDLE) & dp_valid_q & dp_write_q;
        // A write completing this cycle to the same word is merged into the read result
        if (wr_commit_s && (dp_idx_q == acc_idx_s)) begin
            fwd_word_s = merge_bytes(mem_q[acc_idx_s], biu_pad_hwdata, dp_strb_q);
        end else begin
            fwd_word_s = mem_q[acc_idx_s];
        end
    end

    // State register and registered bus outputs
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_idx_q   <= '0;
            dp_strb_q  <= 4'd0;
            hrdata_q   <= 32'd0;
            hready_q   <= 1'b1;
            hresp_q    <= 2'b00;
            err_cnt_q  <= 16'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_idx_q   <= dp_idx_d;
            dp_strb_q  <= dp_strb_d;
            hrdata_q   <= hrdata_d;
            hready_q   <= hready_d;
            hresp_q    <= hresp_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ERR2: begin
                if (acc_s) begin
                    if (legal_s) begin
                        state_d = WAIT_EN ? ST_WAIT : ST_IDLE;
                    end else begin
                        state_d = ST_ERR1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode of the next state, registered so HREADY/HRESP come straight from flops
    always_comb begin
        case (state_d)
            ST_IDLE: begin
                hready_d = 1'b1;
                hresp_d  = 2'b00;
            end
            ST_WAIT: begin
                hready_d = 1'b0;
                hresp_d  = 2'b00;
            end
            ST_ERR1: begin
                hready_d = 1'b0;
                hresp_d  = 2'b01;
            end
            ST_ERR2: begin
                hready_d = 1'b1;
                hresp_d  = 2'b01;
            end
            default: begin
                hready_d = 1'b1;
                hresp_d  = 2'b00;
            end
        endcase
    end

    // Data-phase bookkeeping, wait counter, read-data capture and error counter
    always_comb begin
        if ((state_q != ST_WAIT) && (state_d == ST_WAIT)) begin
            cnt_d = WAIT_LOAD;
        end else if ((state_q == ST_WAIT) && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = cnt_q;
        end

        dp_write_d = dp_write_q;
        dp_idx_d   = dp_idx_q;
        dp_strb_d  = dp_strb_q;
        if (acc_s) begin
            dp_valid_d = legal_s;
            dp_write_d = biu_pad_hwrite;
            dp_idx_d   = acc_idx_s;
            dp_strb_d  = strb_s;
        end else if (state_q == ST_IDLE) begin
            dp_valid_d = 1'b0;
        end else begin
            dp_valid_d = dp_valid_q;
        end

        // Read data is captured on the edge that opens the completing data-phase cycle
        if (!WAIT_EN && acc_s && legal_s && !biu_pad_hwrite) begin
            hrdata_d = fwd_word_s;
        end else if ((state_q == ST_WAIT) && (cnt_q == 4'd0) && !dp_write_q) begin
            hrdata_d = mem_q[dp_idx_q];
        end else begin
            hrdata_d = hrdata_q;
        end

        if ((state_d == ST_ERR1) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Memory array write port; contents are deliberately left unreset
    always_ff @(posedge cpu_clk) begin
        if (wr_commit_s && !cpu_rst) begin
            mem_q[dp_idx_q] <= merge_bytes(mem_q[dp_idx_q], biu_pad_hwdata, dp_strb_q);
        end
    end

    assign pad_biu_hrdata = hrdata_q;
    assign pad_biu_hready = hready_q;
    assign pad_biu_hresp  = hresp_q;
    assign slv_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ahbl_sram_slave.sv
// Bench for ahbl_sram_slave: one zero-wait and one three-wait instance driven by a shared master,
// with a scoreboard of expected data-phase responses checked by a bus monitor.
module tb_ahbl_sram_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        wiggle;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans, tr0, tr3;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst = 3'b001;
    logic [3:0]  hprot  = 4'b0011;
    logic [31:0] rdata0, rdata3, rdata_m;
    logic        hready0, hready3, hready_m;
    logic [1:0]  hresp0, hresp3, hresp_m;
    logic [15:0] errc0, errc3;

    always #5 clk = ~clk;

    assign tr0      = sel ? 2'b00 : htrans;
    assign tr3      = sel ? htrans : 2'b00;
    assign rdata_m  = sel ? rdata3 : rdata0;
    assign hready_m = sel ? hready3 : hready0;
    assign hresp_m  = sel ? hresp3 : hresp0;

    ahbl_sram_slave #(.BASE_ADDR(32'h2000_0000), .DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
        .cpu_clk(clk), .cpu_rst(rst), .biu_pad_haddr(haddr), .biu_pad_htrans(tr0),
        .biu_pad_hwrite(hwrite), .biu_pad_hsize(hsize), .biu_pad_hburst(hburst),
        .biu_pad_hprot(hprot), .biu_pad_hwdata(hwdata), .pad_biu_hrdata(rdata0),
        .pad_biu_hready(hready0), .pad_biu_hresp(hresp0), .slv_err_cnt(errc0));

    ahbl_sram_slave #(.BASE_ADDR(32'h2000_0000), .DEPTH(1024), .WAIT_CYCLES(3)) dut3 (
        .cpu_clk(clk), .cpu_rst(rst), .biu_pad_haddr(haddr), .biu_pad_htrans(tr3),
        .biu_pad_hwrite(hwrite), .biu_pad_hsize(hsize), .biu_pad_hburst(hburst),
        .biu_pad_hprot(hprot), .biu_pad_hwdata(hwdata), .pad_biu_hrdata(rdata3),
        .pad_biu_hready(hready3), .pad_biu_hresp(hresp3), .slv_err_cnt(errc3));

    typedef struct packed {
        logic        is_rd;
        logic [31:0] data;
        logic [1:0]  resp;
        logic [7:0]  lat;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] model [int];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, expv);
        end
    endtask

    // Watches the selected slave; every accepted transfer must match the head of the scoreboard
    task automatic monitor();
        bit   pend = 1'b0;
        int   cyc  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (pend) begin
                    cyc++;
                    if (sbq.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                        pend = 1'b0;
                    end else begin
                        e = sbq[0];
                        chk("hresp", 32'(hresp_m), 32'(e.resp));
                        if (hready_m) begin
                            void'(sbq.pop_front());
                            chk("latency", 32'(cyc), 32'(e.lat));
                            if (e.is_rd) chk("rdata", rdata_m, e.data);
                            pend = 1'b0;
                        end
                    end
                end else begin
                    chk("idle_ready", 32'(hready_m), 32'd1);
                    chk("idle_resp", 32'(hresp_m), 32'd0);
                end
                if (hready_m && htrans[1]) begin
                    pend = 1'b1;
                    cyc  = 0;
                end
            end
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepts the address phase
    task automatic wait_ready();
        logic [31:0] oa;
        logic [1:0]  ot;
        logic        ow;
        logic [2:0]  os;
        int          n;
        oa = haddr; ot = htrans; ow = hwrite; os = hsize; n = 0;
        while (hready_m !== 1'b1 && n < 64) begin
            if (wiggle) begin
                haddr = oa ^ 32'h0000_0004; htrans = 2'b10; hwrite = 1'b1; hsize = 3'd2;
            end
            @(posedge clk); #1;
            n++;
        end
        haddr = oa; htrans = ot; hwrite = ow; hsize = os;
        if (n >= 64) begin
            total++;
            bad++;
            $error("FAIL ready_timeout got=%0d exp=<64", n);
        end
        @(posedge clk); #1;
    endtask

    task automatic xfer(input logic [1:0] tr, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic err);
        exp_t        e;
        int          key;
        logic [31:0] w;
        haddr = a; htrans = tr; hwrite = wr; hsize = sz;
        wait_ready();
        hwdata = wd;
        if (tr[1]) begin
            key     = {19'd0, sel, a[13:2]};
            e.is_rd = !wr && !err;
            e.resp  = err ? 2'b01 : 2'b00;
            e.lat   = err ? 8'd2 : (sel ? 8'd4 : 8'd1);
            e.data  = 32'd0;
            if (!err && wr) begin
                w = model.exists(key) ? model[key] : 32'd0;
                case (sz)
                    3'd0:    w[int'(a[1:0])*8 +: 8]   = wd[int'(a[1:0])*8 +: 8];
                    3'd1:    w[int'(a[1])*16 +: 16]   = wd[int'(a[1])*16 +: 16];
                    default: w = wd;
                endcase
                model[key] = w;
            end else if (!err) begin
                e.data = model[key];
            end
            sbq.push_back(e);
        end
    endtask

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;
    localparam logic [2:0] SZB = 3'd0, SZH = 3'd1, SZW = 3'd2;

    initial begin
        rst = 1'b1; sel = 1'b0; wiggle = 1'b0;
        haddr = 32'h0; hwdata = 32'h0; htrans = IDL; hwrite = 1'b0; hsize = SZW;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_hready0", 32'(hready0), 32'd1);
        chk("rst_hresp0", 32'(hresp0), 32'd0);
        chk("rst_rdata0", rdata0, 32'd0);
        chk("rst_errc0", 32'(errc0), 32'd0);
        chk("rst_hready3", 32'(hready3), 32'd1);
        chk("rst_rdata3", rdata3, 32'd0);

        // Zero-wait slave: forwarding, byte/halfword lanes, errors, IDLE/BUSY interleave
        xfer(NSQ, 1'b1, SZW, 32'h2000_0010, 32'hDEAD_BEEF, 1'b0);
        xfer(NSQ, 1'b0, SZW, 32'h2000_0010, 32'h0, 1'b0);
        xfer(NSQ, 1'b1, SZW, 32'h2000_0010, 32'h0000_0000, 1'b0);
        xfer(NSQ, 1'b1, SZB, 32'h2000_0013, 32'h5A00_0000, 1'b0);
        xfer(NSQ, 1'b0, SZW, 32'h2000_0010, 32'h0, 1'b0);
        xfer(NSQ, 1'b1, SZH, 32'h2000_0012, 32'h1234_0000, 1'b0);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        xfer(NSQ, 1'b0, SZW, 32'h2000_0010, 32'h0, 1'b0);
        xfer(NSQ, 1'b1, SZW, 32'h2000_0000, 32'hCAFE_F00D, 1'b0);
        xfer(NSQ, 1'b1, SZW, 32'h2000_0014, 32'h0102_0304, 1'b0);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        chk("rdata_hold", rdata0, 32'h1234_0000);
        xfer(NSQ, 1'b0, SZW, 32'h2000_1000, 32'h0, 1'b1);
        xfer(NSQ, 1'b1, SZH, 32'h2000_0001, 32'hFFFF_FFFF, 1'b1);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        chk("errc_two", 32'(errc0), 32'd2);
        xfer(NSQ, 1'b1, 3'd3, 32'h2000_0014, 32'hFFFF_FFFF, 1'b1);
        xfer(NSQ, 1'b1, SZW, 32'h2000_0016, 32'hFFFF_FFFF, 1'b1);
        xfer(NSQ, 1'b0, SZW, 32'h2000_0000, 32'h0, 1'b0);
        xfer(NSQ, 1'b0, SZW, 32'h2000_0014, 32'h0, 1'b0);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        chk("errc_four", 32'(errc0), 32'd4);
        xfer(NSQ, 1'b0, SZW, 32'h2000_0010, 32'h0, 1'b0);
        xfer(BSY, 1'b1, SZW, 32'h2000_0000, 32'h1111_1111, 1'b0);
        xfer(SQ,  1'b0, SZW, 32'h2000_0014, 32'h0, 1'b0);
        xfer(IDL, 1'b1, SZW, 32'h2000_0000, 32'h2222_2222, 1'b0);
        xfer(SQ,  1'b1, SZW, 32'h2000_0018, 32'hA5A5_A5A5, 1'b0);
        xfer(BSY, 1'b1, SZW, 32'h2000_0000, 32'h3333_3333, 1'b0);
        xfer(SQ,  1'b0, SZW, 32'h2000_0018, 32'h0, 1'b0);
        xfer(NSQ, 1'b1, SZB, 32'h2000_0001, 32'h0000_7700, 1'b0);
        xfer(NSQ, 1'b0, SZW, 32'h2000_0000, 32'h0, 1'b0);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);

        // Three-wait slave: latency, ignored address changes during waits, error without waits
        sel = 1'b1;
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        xfer(NSQ, 1'b1, SZW, 32'h2000_0040, 32'h0BAD_CAFE, 1'b0);
        xfer(NSQ, 1'b1, SZW, 32'h2000_0044, 32'h4444_4444, 1'b0);
        xfer(NSQ, 1'b0, SZW, 32'h2000_0040, 32'h0, 1'b0);
        wiggle = 1'b1;
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        wiggle = 1'b0;
        xfer(NSQ, 1'b0, SZW, 32'h2000_0044, 32'h0, 1'b0);
        xfer(NSQ, 1'b1, SZW, 32'h2000_0048, 32'h1234_5678, 1'b0);
        xfer(NSQ, 1'b0, SZW, 32'h2000_0048, 32'h0, 1'b0);
        xfer(NSQ, 1'b0, SZW, 32'h2000_1000, 32'h0, 1'b1);
        xfer(NSQ, 1'b1, SZW, 32'h2000_0020, 32'h1111_1111, 1'b0);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        chk("errc3_one", 32'(errc3), 32'd1);

        // Reset while a write sits in its wait states: the write must be dropped
        haddr = 32'h2000_0020; htrans = NSQ; hwrite = 1'b1; hsize = SZW;
        sbq.push_back('{is_rd: 1'b0, data: 32'd0, resp: 2'b00, lat: 8'd4});
        @(posedge clk); #1;
        hwdata = 32'hBAD0_BAD0; htrans = IDL; hwrite = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_hready", 32'(hready3), 32'd1);
        chk("midrst_hresp", 32'(hresp3), 32'd0);
        chk("midrst_rdata", rdata3, 32'd0);
        chk("midrst_errc", 32'(errc3), 32'd0);
        rst = 1'b0;
        sbq.delete();
        xfer(NSQ, 1'b0, SZW, 32'h2000_0020, 32'h0, 1'b0);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);

        // Error counter saturation on the zero-wait slave, preloaded near the top
        sel = 1'b0;
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        force dut0.err_cnt_q = 16'hFFFD;
        @(posedge clk); #1;
        release dut0.err_cnt_q;
        @(posedge clk); #1;
        chk("sat_preload", 32'(errc0), 32'h0000_FFFD);
        xfer(NSQ, 1'b0, SZW, 32'h2000_1000, 32'h0, 1'b1);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        chk("sat_fffe", 32'(errc0), 32'h0000_FFFE);
        xfer(NSQ, 1'b0, SZW, 32'h2000_1000, 32'h0, 1'b1);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        chk("sat_ffff", 32'(errc0), 32'h0000_FFFF);
        xfer(NSQ, 1'b0, SZW, 32'h2000_1000, 32'h0, 1'b1);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        chk("sat_hold", 32'(errc0), 32'h0000_FFFF);
        xfer(IDL, 1'b0, SZW, 32'h0, 32'h0, 1'b0);
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
